// File: rtl/clcd_cmd_arbiter.sv
// N-channel command arbiter in front of the CLCD signal generator command port.
// Channel 0 has top priority; bursts lock the port; busy handshake is supervised with a timeout.
module clcd_cmd_arbiter #(
  parameter int unsigned N_CH         = 3,
  parameter int unsigned MODE         = 1,
  parameter int unsigned BUSY_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic [N_CH-1:0]   i_valid,
  input  logic [8*N_CH-1:0] i_data,
  input  logic [N_CH-1:0]   i_RS,
  input  logic [N_CH-1:0]   i_RW,
  input  logic [N_CH-1:0]   i_last,
  output logic [N_CH-1:0]   o_ack,
  output logic [N_CH-1:0]   o_grant,
  output logic              o_valid,
  output logic [7:0]        o_data,
  output logic              o_RS,
  output logic              o_RW,
  input  logic              i_busy,
  output logic              o_timeout
);

  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_lock_vld;
  logic [IW-1:0]   r_lock_id;
  logic [IW-1:0]   r_ptr;
  logic [N_CH-1:0] r_ack;
  logic [N_CH-1:0] r_grant;
  logic            r_valid;
  logic [7:0]      r_data;
  logic            r_rs;
  logic            r_rw;
  logic            r_timeout;

  logic [N_CH-1:0] w_elig;
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [7:0]      w_ch_data [N_CH];

  function automatic logic [N_CH-1:0] f_onehot(input logic [IW-1:0] idx);
    f_onehot = {{(N_CH-1){1'b0}}, 1'b1} << idx;
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_ch_data[g] = i_data[8*g +: 8];
  end

  always_comb begin
    w_elig  = i_valid;
    w_found = 1'b0;
    w_win   = '0;
    if (r_lock_vld) begin
      w_elig = i_valid & f_onehot(r_lock_id);
    end
    if (MODE == 0) begin
      // Scan downwards so the lowest eligible index is the last one written.
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
        if ((w_elig & f_onehot(IW'(k))) != '0) begin
          w_found = 1'b1;
          w_win   = IW'(k);
        end
      end
    end else begin
      // Round-robin over 1..N_CH-1 starting after r_ptr; channel 0 overrides below.
      for (int off = int'(N_CH) - 1; off >= 1; off--) begin
        automatic int idx = ((int'(r_ptr) - 1 + off) % (int'(N_CH) - 1)) + 1;
        if ((w_elig & f_onehot(IW'(idx))) != '0) begin
          w_found = 1'b1;
          w_win   = IW'(idx);
        end
      end
      if (w_elig[0]) begin
        w_found = 1'b1;
        w_win   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
      r_ptr      <= IW'(N_CH - 1);
      r_ack      <= '0;
      r_grant    <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_rs       <= 1'b0;
      r_rw       <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_ack     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!i_busy && w_found) begin
            r_data     <= w_ch_data[w_win];
            r_rs       <= i_RS[w_win];
            r_rw       <= i_RW[w_win];
            r_ack      <= f_onehot(w_win);
            r_grant    <= f_onehot(w_win);
            r_valid    <= 1'b1;
            r_lock_vld <= !i_last[w_win];
            r_lock_id  <= w_win;
            if (MODE != 0 && w_win != '0) begin
              r_ptr <= w_win;
            end
            r_state <= StIssue;
          end
        end
        StIssue: begin
          r_cnt   <= '0;
          r_state <= StWaitBusy;
        end
        StWaitBusy: begin
          if (i_busy) begin
            r_state <= StWaitDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
              // Generator never answered: drop the command and free the port.
              r_timeout  <= 1'b1;
              r_lock_vld <= 1'b0;
              r_grant    <= '0;
              r_state    <= StIdle;
            end
          end
        end
        StWaitDone: begin
          if (!i_busy) begin
            r_grant <= r_lock_vld ? f_onehot(r_lock_id) : '0;
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  assign o_ack     = r_ack;
  assign o_grant   = r_grant;
  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_RS      = r_rs;
  assign o_RW      = r_rw;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_clcd_cmd_arbiter.sv
// Randomised bench for clcd_cmd_arbiter: a round-robin unit and a fixed-priority unit,
// each compared every cycle against a transaction-timing reference model.
module tb_clcd_cmd_arbiter;

  localparam int N   = 3;
  localparam int DW  = 8 * N;
  localparam int TMO = 15;
  localparam int NU  = 2;  // unit 0: MODE 1, unit 1: MODE 0

  logic clk;
  logic reset_p;

  logic [N-1:0]  valid [NU];
  logic [DW-1:0] data  [NU];
  logic [N-1:0]  rs    [NU];
  logic [N-1:0]  rw    [NU];
  logic [N-1:0]  last  [NU];
  logic          busy  [NU];
  logic [N-1:0]  ack   [NU];
  logic [N-1:0]  grant [NU];
  logic          vld   [NU];
  logic [7:0]    odata [NU];
  logic          ors   [NU];
  logic          orw   [NU];
  logic          tmo   [NU];

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         cyc;
  bit         m_inflight [NU];
  int         m_issue    [NU];
  bit         m_rose     [NU];
  bit         m_lock_v   [NU];
  int         m_lock     [NU];
  int         m_ptr      [NU];
  logic [N-1:0] e_ack    [NU];
  logic [N-1:0] e_grant  [NU];
  bit         e_vld      [NU];
  bit         e_tmo      [NU];
  logic [7:0] e_data     [NU];
  bit         e_rs       [NU];
  bit         e_rw       [NU];

  // Stimulus state
  int burst_left [NU][N];
  int gen_start  [NU];
  int gen_hold   [NU];
  bit gen_quiet  [NU];
  int req_pct;
  int never_pct;
  int n_tmo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  clcd_cmd_arbiter #(.N_CH(N), .MODE(1), .BUSY_TIMEOUT(TMO)) u_rr (
    .clk(clk), .reset_p(reset_p), .i_valid(valid[0]), .i_data(data[0]), .i_RS(rs[0]),
    .i_RW(rw[0]), .i_last(last[0]), .o_ack(ack[0]), .o_grant(grant[0]), .o_valid(vld[0]),
    .o_data(odata[0]), .o_RS(ors[0]), .o_RW(orw[0]), .i_busy(busy[0]), .o_timeout(tmo[0])
  );

  clcd_cmd_arbiter #(.N_CH(N), .MODE(0), .BUSY_TIMEOUT(TMO)) u_fp (
    .clk(clk), .reset_p(reset_p), .i_valid(valid[1]), .i_data(data[1]), .i_RS(rs[1]),
    .i_RW(rw[1]), .i_last(last[1]), .o_ack(ack[1]), .o_grant(grant[1]), .o_valid(vld[1]),
    .o_data(odata[1]), .o_RS(ors[1]), .o_RW(orw[1]), .i_busy(busy[1]), .o_timeout(tmo[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int k);
    return ((v >> k) & N'(1)) != 0;
  endfunction

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] r;
    r = N'(1);
    return r << k;
  endfunction

  function automatic logic [N-1:0] setb(input logic [N-1:0] v, input int k, input bit b);
    return b ? (v | oh(k)) : (v & ~oh(k));
  endfunction

  function automatic logic [7:0] byte_of(input logic [DW-1:0] v, input int k);
    logic [DW-1:0] t;
    t = v >> (8 * k);
    return t[7:0];
  endfunction

  // Winner per the arbitration rules, or -1 when nobody is eligible.
  function automatic int pick(input int u);
    logic [N-1:0] v;
    int c;
    v = valid[u];
    if (m_lock_v[u]) return bit_of(v, m_lock[u]) ? m_lock[u] : -1;
    if (bit_of(v, 0)) return 0;
    if (u == 1) begin
      for (int k = 1; k < N; k++) if (bit_of(v, k)) return k;
      return -1;
    end
    for (int s = 1; s < N; s++) begin
      c = m_ptr[u] + s;
      if (c >= N) c = c - (N - 1);
      if (bit_of(v, c)) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      m_inflight[u] = 1'b0;
      m_rose[u]     = 1'b0;
      m_lock_v[u]   = 1'b0;
      m_lock[u]     = 0;
      m_ptr[u]      = N - 1;
      e_ack[u]      = '0;
      e_grant[u]    = '0;
      e_vld[u]      = 1'b0;
      e_tmo[u]      = 1'b0;
      e_data[u]     = '0;
      e_rs[u]       = 1'b0;
      e_rw[u]       = 1'b0;
      busy[u]       = 1'b0;
      gen_start[u]  = -1;
      gen_hold[u]   = 0;
      gen_quiet[u]  = 1'b0;
    end
  endtask

  // Inputs of cycle cyc decide outputs of cycle cyc+1; the command strobe appears in m_issue.
  task automatic model_step(input int u);
    int w;
    e_ack[u] = '0;
    e_vld[u] = 1'b0;
    e_tmo[u] = 1'b0;
    if (!m_inflight[u]) begin
      w = pick(u);
      if (!busy[u] && w >= 0) begin
        e_ack[u]      = oh(w);
        e_grant[u]    = oh(w);
        e_vld[u]      = 1'b1;
        e_data[u]     = byte_of(data[u], w);
        e_rs[u]       = bit_of(rs[u], w);
        e_rw[u]       = bit_of(rw[u], w);
        m_lock_v[u]   = !bit_of(last[u], w);
        m_lock[u]     = w;
        if (w != 0) m_ptr[u] = w;
        m_inflight[u] = 1'b1;
        m_issue[u]    = cyc + 1;
        m_rose[u]     = 1'b0;
      end
    end else if (cyc == m_issue[u]) begin
      // strobe cycle: busy not yet looked at
    end else if (!m_rose[u]) begin
      if (busy[u]) begin
        m_rose[u] = 1'b1;
      end else if (cyc - m_issue[u] == TMO) begin
        e_tmo[u]      = 1'b1;
        m_lock_v[u]   = 1'b0;
        e_grant[u]    = '0;
        m_inflight[u] = 1'b0;
      end
    end else if (!busy[u]) begin
      m_inflight[u] = 1'b0;
      e_grant[u]    = m_lock_v[u] ? oh(m_lock[u]) : '0;
    end
  endtask

  task automatic compare_unit(input int u);
    check_eq($sformatf("u%0d ack", u), 32'(ack[u]), 32'(e_ack[u]));
    check_eq($sformatf("u%0d grant", u), 32'(grant[u]), 32'(e_grant[u]));
    check_eq($sformatf("u%0d valid", u), 32'(vld[u]), 32'(e_vld[u]));
    check_eq($sformatf("u%0d timeout", u), 32'(tmo[u]), 32'(e_tmo[u]));
    check_eq($sformatf("u%0d data", u), 32'(odata[u]), 32'(e_data[u]));
    check_eq($sformatf("u%0d rs", u), 32'(ors[u]), 32'(e_rs[u]));
    check_eq($sformatf("u%0d rw", u), 32'(orw[u]), 32'(e_rw[u]));
  endtask

  task automatic check_zero(input string when);
    for (int u = 0; u < NU; u++) begin
      check_eq($sformatf("%s u%0d ack", when, u), 32'(ack[u]), 32'd0);
      check_eq($sformatf("%s u%0d grant", when, u), 32'(grant[u]), 32'd0);
      check_eq($sformatf("%s u%0d valid", when, u), 32'(vld[u]), 32'd0);
      check_eq($sformatf("%s u%0d data", when, u), 32'(odata[u]), 32'd0);
      check_eq($sformatf("%s u%0d rsrw", when, u), 32'({ors[u], orw[u]}), 32'd0);
      check_eq($sformatf("%s u%0d timeout", when, u), 32'(tmo[u]), 32'd0);
    end
  endtask

  task automatic new_cmd(input int u, input int k);
    logic [DW-1:0] m;
    logic [DW-1:0] d;
    if (burst_left[u][k] == 0)
      burst_left[u][k] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 17)) : 1;
    burst_left[u][k]--;
    m = DW'(8'hFF) << (8 * k);
    d = DW'($urandom_range(0, 255)) << (8 * k);
    data[u]  = (data[u] & ~m) | d;
    rs[u]    = setb(rs[u], k, 1'($urandom_range(0, 1)));
    rw[u]    = setb(rw[u], k, 1'($urandom_range(0, 1)));
    last[u]  = setb(last[u], k, burst_left[u][k] == 0);
    valid[u] = setb(valid[u], k, 1'b1);
  endtask

  task automatic drive_src(input int u);
    for (int k = 0; k < N; k++) begin
      if (bit_of(ack[u], k)) begin
        if (burst_left[u][k] > 0 || $urandom_range(0, 99) < req_pct) new_cmd(u, k);
        else valid[u] = setb(valid[u], k, 1'b0);
      end else if (!bit_of(valid[u], k)) begin
        if ($urandom_range(0, 99) < req_pct) new_cmd(u, k);
      end else if ($urandom_range(0, 199) == 0) begin
        valid[u] = setb(valid[u], k, 1'b0);
      end
    end
  endtask

  // Generator model: busy rises 0..3 cycles after the strobe and holds 1..6 cycles,
  // sometimes never answers, and occasionally goes busy on its own while idle.
  task automatic drive_gen(input int u);
    if (tmo[u]) begin
      gen_quiet[u] = 1'b0;
      n_tmo++;
    end
    if (vld[u]) begin
      if ($urandom_range(0, 99) < never_pct) begin
        gen_quiet[u] = 1'b1;
        gen_start[u] = -1;
      end else begin
        gen_start[u] = $urandom_range(0, 3);
        gen_hold[u]  = $urandom_range(1, 6);
      end
    end
    if (gen_start[u] == 0) begin
      busy[u]      = 1'b1;
      gen_start[u] = -1;
    end else if (gen_start[u] > 0) begin
      gen_start[u]--;
    end else if (busy[u]) begin
      gen_hold[u]--;
      if (gen_hold[u] <= 0) busy[u] = 1'b0;
    end else if (!gen_quiet[u] && $urandom_range(0, 99) < 3) begin
      busy[u]     = 1'b1;
      gen_hold[u] = $urandom_range(1, 3);
    end
  endtask

  // Reset unit 0 while it waits for busy to fall with a burst lock held.
  task automatic do_reset_mid();
    int n;
    n = 0;
    while (!(m_inflight[0] && m_rose[0] && m_lock_v[0]) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_target_reached", 32'(n < 4000), 32'd1);
    #2 reset_p = 1'b1;
    #1 check_zero("mid_rst");
    model_reset();
    repeat (2) @(negedge clk);
    #2 reset_p = 1'b0;
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      if (!reset_p) for (int u = 0; u < NU; u++) model_step(u);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_p) begin
        for (int u = 0; u < NU; u++) begin
          compare_unit(u);
          drive_gen(u);
          drive_src(u);
        end
      end
    end
  end

  initial begin
    reset_p   = 1'b0;
    req_pct   = 30;
    never_pct = 5;
    n_tmo     = 0;
    for (int u = 0; u < NU; u++) begin
      valid[u] = '0;
      data[u]  = '0;
      rs[u]    = '0;
      rw[u]    = '0;
      last[u]  = '0;
      for (int k = 0; k < N; k++) burst_left[u][k] = 0;
    end
    model_reset();
    #1 reset_p = 1'b1;
    #2 check_zero("por");
    repeat (3) @(negedge clk);
    #2 reset_p = 1'b0;

    repeat (2500) @(negedge clk);
    never_pct = 70;
    repeat (800) @(negedge clk);
    never_pct = 5;
    req_pct   = 80;
    repeat (1500) @(negedge clk);
    do_reset_mid();
    req_pct = 40;
    repeat (1500) @(negedge clk);

    check_eq("seen_timeout", 32'(n_tmo > 0), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clcd_cmd_arbiter.md
Name: clcd_cmd_arbiter

Overview:
- Parametrised N-channel command arbiter that merges several CLCD command sources onto the single CLCD_signal_generator command port: init register bank, system control, keypad echo and future sources.
- Replaces the fixed two-way empty-flag mux.
- Adds a selectable arbitration mode, per-channel ack, multi-command burst locking (no interleaving inside a text line) and busy-handshake supervision with timeout.

Parameters:
- N_CH, 3, number of request channels (>=2); channel 0 = init bank, always highest priority.
- MODE, 1, 0 = fixed priority (lowest index wins); 1 = channel 0 first, then round-robin over 1..N_CH-1.
- BUSY_TIMEOUT, 1023, clk cycles allowed between o_valid and i_busy rising; timeout counter width = clog2(BUSY_TIMEOUT+1).

Ports:
- clk  in  1  system clock
- reset_p  in  1  asynchronous active-high reset
- i_valid  in  N_CH  per-channel command request
- i_data  in  8*N_CH  per-channel byte; channel k at [8k+7:8k]
- i_RS  in  N_CH  per-channel register select
- i_RW  in  N_CH  per-channel read/write
- i_last  in  N_CH  1 = command ends the channel's burst
- o_ack  out  N_CH  one-cycle pulse: channel's command captured
- o_grant  out  N_CH  one-hot owner (in-flight or locked channel)
- o_valid  out  1  command strobe to CLCD generator
- o_data  out  8  command byte
- o_RS  out  1  register select
- o_RW  out  1  read/write
- i_busy  in  1  CLCD generator busy
- o_timeout  out  1  one-cycle pulse: busy never rose

Behaviour:
- Reset (asynchronous, reset_p=1): all outputs 0, state IDLE, lock cleared, RR pointer = N_CH-1 so channel 1 wins first. Reset mid-command abandons it; no ack or timeout is issued afterwards.
- IDLE: when i_busy=0 and at least one eligible i_valid is set, select winner w. Same edge: latch data/RS/RW of w, pulse o_ack[w], set o_grant to one-hot w, go ISSUE. If i_busy=1, wait.
- Eligibility: if a lock is held, only the lock owner is eligible; otherwise all channels.
- MODE 0: lowest eligible index wins.
- MODE 1: channel 0 wins if valid. Otherwise first valid index after the RR pointer, wrapping within 1..N_CH-1. Pointer updates to w on each grant to a channel >=1.
- Lock: capturing a command with i_last=0 sets lock=w. Capturing one with i_last=1 clears the lock. Channel 0 cannot pre-empt another channel's lock.
- ISSUE: o_valid=1 for exactly one cycle with the latched fields; go WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY: i_busy=1 goes to WAIT_DONE. Otherwise the counter increments. When the counter reaches BUSY_TIMEOUT: pulse o_timeout, clear the lock, go IDLE. The command is dropped, not retried.
- WAIT_DONE: i_busy=0 goes to IDLE. No timeout in this state.
- o_data/o_RS/o_RW hold the last issued command until the next capture.
- o_grant: 0 in IDLE when no lock is held; otherwise one-hot owner.
- Throughput: at most one command per 4 clk (IDLE, ISSUE, >=1 WAIT_BUSY, >=1 WAIT_DONE).
- Source rule: hold valid and fields stable until ack. A request withdrawn before ack is simply not granted. After ack, the source may present its next command immediately; it is considered on the next IDLE.
- Simultaneous events:
  - A new request arriving on the same cycle WAIT_DONE sees i_busy fall is evaluated on the following IDLE cycle.
  - i_busy already high on the cycle after ISSUE counts as busy rise.

Test Plan:
- MODE=1, N_CH=3, channels 0 and 2 valid together, generator model (busy 2 cycles after o_valid, held 5 cycles) -> ch0 acked first, o_data=ch0 byte; ch2 issued only after i_busy falls; exactly one o_valid per command.
- MODE=1, channels 1 and 2 continuously valid, i_last=1 -> grants alternate 1,2,1,2 starting with 1 after reset; MODE=0, same stimulus -> only channel 1 served.
- Channel 2 burst of 17 commands (cursor 0x80 + 16 chars), i_last=1 on the 17th; channel 0 asserted mid-burst -> all 17 issued contiguously, o_grant=3'b100 throughout; ch0 served after.
- Busy model never asserts, BUSY_TIMEOUT=15 -> o_timeout pulses exactly 16 cycles after o_valid; lock released; next channel granted.
- reset_p pulsed while in WAIT_DONE with lock held -> all outputs 0 immediately; after release, a pending channel 1 request is granted first with no stale ack.
- i_busy held high with requests pending -> no ack/o_valid until i_busy low, then grant on the first low cycle.
